// File: rtl/booth8_mul_pipe.sv
// booth8_mul_pipe: three-stage radix-8 Booth multiplier with valid/ready flow control.
//   S1 registers the operands, S2 recodes the multiplier into radix-8 digits, builds 3X
//   and selects one partial product per digit, and S3 sums the partial products together
//   with the correction bits and registers the product.
// Optional feature macro: MUL_NEG_EN adds the i_negate port. When it is set the beat's
// result is the two's-complement negation of a*b. Latency is unchanged.
// A single advance signal stalls the whole pipeline whenever a result is held back.
module booth8_mul_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic               i_signed,
`ifdef MUL_NEG_EN
  input  logic               i_negate,
`endif
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int GROUPS = (WIDTH + 3) / 3;  // radix-8 digit count
  localparam int PW     = 2 * WIDTH;        // product width
  localparam int AW     = WIDTH + 3;        // room for +/-4X of a signed or unsigned a
  localparam int BX     = 3 * GROUPS + 1;   // recoded multiplier width incl. the implicit 0

  // Per-digit magnitude of a 4-bit overlapping Booth window (-4..+4 -> 0..4).
  function automatic logic [2:0] booth_mag(input logic [3:0] w);
    case (w)
      4'b0000, 4'b1111:                   booth_mag = 3'd0;
      4'b0001, 4'b0010, 4'b1101, 4'b1110: booth_mag = 3'd1;
      4'b0011, 4'b0100, 4'b1011, 4'b1100: booth_mag = 3'd2;
      4'b0101, 4'b0110, 4'b1001, 4'b1010: booth_mag = 3'd3;
      default:                            booth_mag = 3'd4;
    endcase
  endfunction

  // Negation request of the incoming beat; tied low when the feature is compiled out.
  logic neg_in;
`ifdef MUL_NEG_EN
  assign neg_in = i_negate;
`else
  assign neg_in = 1'b0;
`endif

  // Global advance: the pipeline moves whenever the output slot is empty or draining.
  logic adv;
  assign adv     = !o_valid_q || i_ready;
  assign o_ready = adv;

  // ---------------------------------------------------------------- S1
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic             s1_signed_q;
  logic             s1_neg_q;

  // S1: capture the operand beat together with its mode bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_signed_q <= 1'b0;
      s1_neg_q    <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= i_valid;
      if (i_valid) begin
        s1_a_q      <= i_a;
        s1_b_q      <= i_b;
        s1_signed_q <= i_signed;
        s1_neg_q    <= neg_in;
      end
    end
  end

  // ---------------------------------------------------------------- S2
  // Extended multiplicand and its small multiples; 3X is the only true adder here.
  logic          a_sx;
  logic          b_sx;
  logic [AW-1:0] a_ext;
  logic [AW-1:0] a_x2;
  logic [AW-1:0] a_x3;
  logic [AW-1:0] a_x4;
  logic [BX-1:0] b_ext;

  assign a_sx  = s1_signed_q & s1_a_q[WIDTH-1];
  assign b_sx  = s1_signed_q & s1_b_q[WIDTH-1];
  assign a_ext = {{3{a_sx}}, s1_a_q};
  assign a_x2  = a_ext << 1;
  assign a_x4  = a_ext << 2;
  assign a_x3  = a_ext + a_x2;
  // Multiplier with the implicit zero below bit 0 and sign/zero padding on top.
  assign b_ext = {{(BX - WIDTH - 1){b_sx}}, s1_b_q, 1'b0};

  logic s2_valid_q;
  logic s2_neg_q;

  // S2 control: valid and negate flag follow the beat out of S1.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_neg_q   <= 1'b0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_neg_q <= s1_neg_q;
      end
    end
  end

  // Running sum of partial products plus correction bits, built digit by digit in S3.
  logic [PW-1:0] acc_w [GROUPS+1];
  assign acc_w[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < GROUPS; gi++) begin : g_digit
      logic [3:0]    win;
      logic [2:0]    mag;
      logic          nd_d;
      logic [AW-1:0] sel;
      logic [PW-1:0] sel_x;
      logic [PW-1:0] pp_d;
      logic [PW-1:0] pp_q;
      logic          nd_q;
      logic [PW-1:0] corr;

      assign win  = b_ext[3*gi +: 4];
      assign mag  = booth_mag(win);
      // Negative digit unless the window is all ones (which encodes zero).
      assign nd_d = win[3] & ~(&win[2:0]);

      // Select the multiple of a named by this digit's magnitude.
      always_comb begin
        sel = '0;
        case (mag)
          3'd1:    sel = a_ext;
          3'd2:    sel = a_x2;
          3'd3:    sel = a_x3;
          3'd4:    sel = a_x4;
          default: sel = '0;
        endcase
      end

      // Negative digits use the one's complement here; the +1 is added back in S3
      // at bit 3*gi, which is exactly where the shifted complement is one short.
      assign sel_x = {{(PW - AW){sel[AW-1]}}, sel};
      assign pp_d  = (nd_d ? ~sel_x : sel_x) << (3 * gi);

      // S2 data: this digit's weighted partial product and its correction flag.
      always_ff @(posedge clk) begin
        if (rst) begin
          pp_q <= '0;
          nd_q <= 1'b0;
        end else if (adv && s1_valid_q) begin
          pp_q <= pp_d;
          nd_q <= nd_d;
        end
      end

      assign corr           = nd_q ? (PW'(1) << (3 * gi)) : '0;
      assign acc_w[gi + 1]  = acc_w[gi] + pp_q + corr;
    end
  endgenerate

  // ---------------------------------------------------------------- S3
  logic [PW-1:0] prod_d;
  logic          o_valid_q;
  logic [PW-1:0] o_product_q;

  // Optional negation of the completed sum, modulo 2^(2*WIDTH).
  assign prod_d = s2_neg_q ? (PW'(0) - acc_w[GROUPS]) : acc_w[GROUPS];

  // S3: output register; holds value and valid while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid_q   <= 1'b0;
      o_product_q <= '0;
    end else if (adv) begin
      o_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        o_product_q <= prod_d;
      end
    end
  end

  assign o_valid   = o_valid_q;
  assign o_product = o_product_q;

endmodule

// File: tb/tb_booth8_mul_pipe.sv
// Self-checking bench for booth8_mul_pipe: WIDTH=8 (directed + random) and WIDTH=13 (random)
// instances checked against an arithmetic reference model with in-order scoreboards.
module tb_booth8_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- WIDTH = 8 instance
  logic        rst8, iv8, or8, s8, n8, ov8, ir8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  booth8_mul_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .i_valid(iv8), .o_ready(or8),
    .i_a(a8), .i_b(b8), .i_signed(s8),
`ifdef MUL_NEG_EN
    .i_negate(n8),
`endif
    .o_valid(ov8), .i_ready(ir8), .o_product(p8)
  );

  // ---------------- WIDTH = 13 instance
  logic        rst13, iv13, or13, s13, n13, ov13, ir13;
  logic [12:0] a13, b13;
  logic [25:0] p13;

  booth8_mul_pipe #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst13), .i_valid(iv13), .o_ready(or13),
    .i_a(a13), .i_b(b13), .i_signed(s13),
`ifdef MUL_NEG_EN
    .i_negate(n13),
`endif
    .o_valid(ov13), .i_ready(ir13), .o_product(p13)
  );

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: interpret operands per mode, multiply as integers, optionally negate, wrap.
  function automatic longint model(input longint a, input longint b, input int w,
                                   input bit s, input bit n);
    longint av = a;
    longint bv = b;
    longint p;
    if (s && a[w-1]) av = a - (longint'(1) << w);
    if (s && b[w-1]) bv = b - (longint'(1) << w);
    p = av * bv;
    if (n) p = -p;
    return p & ((longint'(1) << (2 * w)) - 1);
  endfunction

  // ---------------- scoreboard / compare process, WIDTH = 8
  longint exp8_q[$];
  longint got8_q[$];
  int     acc8_q[$];
  int     lat8_q[$];
  int     acc8_n = 0;
  bit     rst_seen8 = 0;
  bit     hold8 = 0;
  longint held8 = 0;
  longint e8;
  int     ac8;

  always @(negedge clk) begin
    if (rst8) begin
      exp8_q.delete();
      acc8_q.delete();
      rst_seen8 = 1;
      hold8 = 0;
    end else begin
      if (rst_seen8) begin
        chk(!ov8, "w8 reset o_valid", longint'(ov8), 0);
        chk(p8 == 16'h0, "w8 reset o_product", longint'(p8), 0);
        chk(or8, "w8 reset o_ready", longint'(or8), 1);
        rst_seen8 = 0;
      end
      chk(or8 == (!ov8 || ir8), "w8 o_ready", longint'(or8), longint'(!ov8 || ir8));
      if (hold8) chk(ov8 && longint'(p8) == held8, "w8 stall hold", longint'(p8), held8);
      if (ov8 && ir8) begin
        chk(exp8_q.size() != 0, "w8 output expected", longint'(p8), 0);
        if (exp8_q.size() != 0) begin
          e8  = exp8_q.pop_front();
          ac8 = acc8_q.pop_front();
          chk(longint'(p8) == e8, "w8 product", longint'(p8), e8);
          got8_q.push_back(longint'(p8));
          lat8_q.push_back(cyc - ac8);
        end
      end
      hold8 = ov8 && !ir8;
      held8 = longint'(p8);
      if (iv8 && or8) begin
        exp8_q.push_back(model(longint'(a8), longint'(b8), 8, s8, n8));
        acc8_q.push_back(cyc);
        acc8_n++;
      end
    end
  end

  // ---------------- scoreboard / compare process, WIDTH = 13
  longint exp13_q[$];
  int     acc13_n = 0;
  bit     rst_seen13 = 0;
  bit     hold13 = 0;
  longint held13 = 0;
  longint e13;

  always @(negedge clk) begin
    if (rst13) begin
      exp13_q.delete();
      rst_seen13 = 1;
      hold13 = 0;
    end else begin
      if (rst_seen13) begin
        chk(!ov13 && p13 == 26'h0, "w13 reset state", longint'(p13), 0);
        rst_seen13 = 0;
      end
      chk(or13 == (!ov13 || ir13), "w13 o_ready", longint'(or13), longint'(!ov13 || ir13));
      if (hold13) chk(ov13 && longint'(p13) == held13, "w13 stall hold", longint'(p13), held13);
      if (ov13 && ir13) begin
        chk(exp13_q.size() != 0, "w13 output expected", longint'(p13), 0);
        if (exp13_q.size() != 0) begin
          e13 = exp13_q.pop_front();
          chk(longint'(p13) == e13, "w13 product", longint'(p13), e13);
        end
      end
      hold13 = ov13 && !ir13;
      held13 = longint'(p13);
      if (iv13 && or13) begin
        exp13_q.push_back(model(longint'(a13), longint'(b13), 13, s13, n13));
        acc13_n++;
      end
    end
  end

  // ---------------- stimulus helpers, WIDTH = 8
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic n);
    bit took = 0;
    int g = 0;
    iv8 = 1'b1; a8 = a; b8 = b; s8 = s; n8 = n;
    do begin
      @(negedge clk);
      took = or8;
      @(posedge clk);
      #1;
      g++;
    end while (!took && g < 50);
    chk(took, "w8 send accepted", longint'(took), 1);
    iv8 = 1'b0;
  endtask

  task automatic wait_idle8();
    int g = 0;
    while ((exp8_q.size() != 0 || ov8) && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk(g < 200, "w8 drain timeout", longint'(g), 200);
  endtask

  task automatic chk_got8(input int i, input longint lit, input string name);
    chk(got8_q.size() > i && got8_q[i] == lit, name,
        (got8_q.size() > i) ? got8_q[i] : -1, lit);
  endtask

  function automatic void clear_log8();
    got8_q.delete();
    lat8_q.delete();
  endfunction

  // ---------------- WIDTH = 13 random process
  bit done13 = 0;
  int rc13 = 0;
  int g13 = 0;

  initial begin
    rst13 = 1'b1; iv13 = 1'b0; ir13 = 1'b1; a13 = '0; b13 = '0; s13 = 1'b0; n13 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst13 = 1'b0;
    while (acc13_n < 10000 && rc13 < 40000) begin
      iv13 = ($urandom_range(0, 3) != 0);
      a13  = 13'($urandom_range(0, 8191));
      b13  = 13'($urandom_range(0, 8191));
      s13  = 1'($urandom_range(0, 1));
`ifdef MUL_NEG_EN
      n13  = 1'($urandom_range(0, 1));
`endif
      ir13 = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
      rc13++;
    end
    iv13 = 1'b0;
    ir13 = 1'b1;
    while ((exp13_q.size() != 0 || ov13) && g13 < 200) begin
      @(posedge clk);
      #1;
      g13++;
    end
    chk(g13 < 200, "w13 drain timeout", longint'(g13), 200);
    done13 = 1;
  end

  // ---------------- main sequence, WIDTH = 8
  int sg = 0;
  int rc8 = 0;
  int acc_start = 0;
  int wg = 0;

  initial begin
    rst8 = 1'b1; iv8 = 1'b0; ir8 = 1'b1; a8 = '0; b8 = '0; s8 = 1'b0; n8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst8 = 1'b0;
    @(posedge clk);
    #1;

    // 1: unsigned 0xFF*0xFF with a fixed 3-clock latency
    clear_log8();
    send8(8'hFF, 8'hFF, 1'b0, 1'b0);
    wait_idle8();
    chk_got8(0, 64'hFE01, "t1 ff*ff");
    chk(lat8_q.size() > 0 && lat8_q[0] == 3, "t1 latency",
        (lat8_q.size() > 0) ? longint'(lat8_q[0]) : -1, 3);

    // 2: mixed signed/unsigned beats back to back
    clear_log8();
    send8(8'h80, 8'h80, 1'b1, 1'b0);
    send8(8'hFF, 8'h7F, 1'b1, 1'b0);
    send8(8'hFF, 8'h7F, 1'b0, 1'b0);
    wait_idle8();
    chk_got8(0, 64'h4000, "t2 s 80*80");
    chk_got8(1, 64'hFF81, "t2 s ff*7f");
    chk_got8(2, 64'h7E81, "t2 u ff*7f");

    // 3: four-beat stream with a two-cycle consumer stall
    clear_log8();
    ir8 = 1'b0;
    fork
      begin
        send8(8'd2, 8'd3, 1'b0, 1'b0);
        send8(8'd7, 8'd9, 1'b0, 1'b0);
        send8(8'd0, 8'hAB, 1'b0, 1'b0);
        send8(8'd1, 8'd1, 1'b0, 1'b0);
      end
      begin
        sg = 0;
        do begin
          @(negedge clk);
          sg++;
        end while (!ov8 && sg < 50);
        chk(ov8, "t3 stall reached", longint'(ov8), 1);
        chk(!or8, "t3 o_ready stall c1", longint'(or8), 0);
        @(negedge clk);
        chk(!or8, "t3 o_ready stall c2", longint'(or8), 0);
        @(posedge clk);
        #1;
        ir8 = 1'b1;
      end
    join
    wait_idle8();
    chk(got8_q.size() == 4, "t3 count", longint'(got8_q.size()), 4);
    chk_got8(0, 64'd6, "t3 2*3");
    chk_got8(1, 64'd63, "t3 7*9");
    chk_got8(2, 64'd0, "t3 0*ab");
    chk_got8(3, 64'd1, "t3 1*1");

    // 4: reset with three beats in flight, then a fresh beat
    clear_log8();
    send8(8'd1, 8'd2, 1'b0, 1'b0);
    send8(8'd3, 8'd4, 1'b0, 1'b0);
    send8(8'd9, 8'd6, 1'b0, 1'b0);
    rst8 = 1'b1;
    @(posedge clk);
    #1;
    rst8 = 1'b0;
    send8(8'd5, 8'd5, 1'b0, 1'b0);
    wait_idle8();
    chk(got8_q.size() == 1, "t4 count", longint'(got8_q.size()), 1);
    chk_got8(0, 64'd25, "t4 5*5");

`ifdef MUL_NEG_EN
    // 5: negated result
    clear_log8();
    send8(8'd3, 8'd5, 1'b0, 1'b1);
    send8(8'd3, 8'd5, 1'b0, 1'b0);
    wait_idle8();
    chk_got8(0, 64'hFFF1, "t5 -(3*5)");
    chk_got8(1, 64'h000F, "t5 3*5");
`endif

    // 6: random beats with random backpressure
    acc_start = acc8_n;
    while (acc8_n - acc_start < 10000 && rc8 < 40000) begin
      iv8 = ($urandom_range(0, 3) != 0);
      a8  = 8'($urandom_range(0, 255));
      b8  = 8'($urandom_range(0, 255));
      s8  = 1'($urandom_range(0, 1));
`ifdef MUL_NEG_EN
      n8  = 1'($urandom_range(0, 1));
`endif
      ir8 = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
      rc8++;
    end
    iv8 = 1'b0;
    ir8 = 1'b1;
    wait_idle8();
    chk(acc8_n - acc_start >= 10000, "t6 w8 beat count", longint'(acc8_n - acc_start), 10000);

    while (!done13 && wg < 60000) begin
      @(posedge clk);
      #1;
      wg++;
    end
    chk(done13, "w13 completion", longint'(done13), 1);
    chk(acc13_n >= 10000, "t6 w13 beat count", longint'(acc13_n), 10000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
